// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared encodings and FSM states for the I-cache refill responder
package icache_refill_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam int BEAT_BYTES = 8;
  typedef enum logic [1:0] {IDLE, WAIT, READ, DATA} state_t;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next-beat address plus 4 KB-cross and WRAP-length legality checks
module axi_burst_addr_gen
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              cross_4k,
  output logic              wrap_len_bad
);
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] mask;
  logic [12:0]       last_off;
  always_comb begin
    incr         = addr + ADDR_W'(BEAT_BYTES);
    mask         = ADDR_W'({len, 3'b111});
    last_off     = {1'b0, addr[11:0]} + {2'b00, len, 3'b000};
    next_addr    = burst == BURST_FIXED ? addr :
                   burst == BURST_WRAP  ? (addr & ~mask) | (incr & mask) : incr;
    cross_4k     = burst == BURST_INCR && last_off[12];
    wrap_len_bad = burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
  end
endmodule

// File: rtl/icache_refill_responder.sv
// icache_refill_responder: AXI4 read-burst responder serving I-cache refills from a synchronous memory port
module icache_refill_responder
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4,
  parameter int LATENCY = 2,
  parameter int MAX_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [7:0]        ar_len,
  input  logic [1:0]        ar_burst,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic [ID_W-1:0]   r_id,
  output logic [1:0]        r_resp,
  output logic              r_last,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, g_addr, next_addr;
  logic [ID_W-1:0]   id;
  logic [7:0]        len, beat, g_len;
  logic [1:0]        burst, g_burst;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       lat_cnt;
  logic              err, ar_err, fresh, cross_4k, wrap_len_bad, accept, hs;
  assign g_addr  = state == IDLE ? ar_addr : addr;
  assign g_len   = state == IDLE ? ar_len : len;
  assign g_burst = state == IDLE ? ar_burst : burst;
  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr         (g_addr),
    .len          (g_len),
    .burst        (g_burst),
    .next_addr    (next_addr),
    .cross_4k     (cross_4k),
    .wrap_len_bad (wrap_len_bad)
  );
  assign ar_ready = state == IDLE && !rst;
  assign r_valid  = state == DATA;
  assign r_last   = r_valid && beat == len;
  assign mem_ren  = state == READ && !err;
  assign mem_addr = addr;
  assign r_id     = id;
  assign r_resp   = err ? RESP_SLVERR : RESP_OKAY;
  assign r_data   = err ? '0 : fresh ? mem_rdata : data_q;
  always_comb begin
    accept   = ar_valid && ar_ready;
    hs       = r_valid && r_ready;
    ar_err   = ar_addr[2:0] != 3'd0 || {1'b0, ar_len} >= 9'(MAX_LEN) || ar_burst == 2'd3 ||
               cross_4k || wrap_len_bad;
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? ((LATENCY > 0 && !ar_err) ? WAIT : READ) : IDLE;
      WAIT: state_nx = lat_cnt == 16'(LATENCY - 1) ? READ : WAIT;
      READ: state_nx = DATA;
      DATA: state_nx = hs ? (r_last ? IDLE : READ) : DATA;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr    <= '0;
      id      <= '0;
      len     <= '0;
      burst   <= '0;
      err     <= 1'b0;
      beat    <= '0;
      lat_cnt <= '0;
      fresh   <= 1'b0;
      data_q  <= '0;
    end else begin
      fresh <= state == READ;
      if (fresh) data_q <= mem_rdata;
      if (state == WAIT) lat_cnt <= lat_cnt + 16'd1;
      if (accept) begin
        addr    <= ar_addr;
        id      <= ar_id;
        len     <= ar_len;
        burst   <= ar_burst;
        err     <= ar_err;
        beat    <= '0;
        lat_cnt <= '0;
      end
      if (hs && !r_last) begin
        addr <= next_addr;
        beat <= beat + 8'd1;
      end
    end
endmodule

// File: tb/tb_icache_refill_responder.sv
// tb_icache_refill_responder: directed self-checking bench for the refill responder
module tb_icache_refill_responder;
  import icache_refill_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [63:0] ar_addr = '0;
  logic [3:0]  ar_id = '0;
  logic [7:0]  ar_len = '0;
  logic [1:0]  ar_burst = '0;
  logic        r_valid;
  logic        r_ready = 1'b1;
  logic [63:0] r_data;
  logic [3:0]  r_id;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        mem_ren;
  logic [63:0] mem_addr;
  logic [63:0] mem_rdata = '0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ren_cnt = 0;
  int acc_cyc = 0;
  int stall_ren = 0;
  logic [63:0] alog [0:63];
  logic [63:0] b_data [0:15];
  logic        b_last [0:15];
  logic [1:0]  b_resp [0:15];
  logic [3:0]  b_id [0:15];
  int          b_cyc [0:15];
  logic        stable_bad, ar_busy_bad;
  icache_refill_responder #(.ADDR_W(64), .DATA_W(64), .ID_W(4), .LATENCY(2), .MAX_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id),
    .r_resp(r_resp), .r_last(r_last),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return a == 64'h8000_0000 ? 64'h0000_0013_0000_0093 : {a[31:0] ^ 32'hDEAD_BEEF, a[31:0]};
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (mem_ren) begin
      mem_rdata <= mem_word(mem_addr);
      if (ren_cnt < 64) alog[ren_cnt] <= mem_addr;
      ren_cnt <= ren_cnt + 1;
    end
  task automatic send_ar(input logic [63:0] a, input logic [3:0] i, input logic [7:0] l, input logic [1:0] b);
    int g = 0;
    @(negedge clk);
    ar_valid = 1'b1; ar_addr = a; ar_id = i; ar_len = l; ar_burst = b;
    while (!ar_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    tests++;
    if (ar_ready !== 1'b1) begin
      fails++;
      $display("FAIL ar_accept: ar_ready=%b required 1", ar_ready);
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1 ar_valid = 1'b0;
  endtask
  task automatic collect(input int n, input int stall_beat, input int stall_len);
    int got = 0;
    int g = 0;
    int r0;
    logic [63:0] sd;
    logic sl;
    logic [3:0] si;
    logic [1:0] sr;
    stable_bad = 1'b0; ar_busy_bad = 1'b0; stall_ren = 0;
    while (got < n && g < 400) begin
      @(negedge clk);
      g++;
      if (ar_ready) ar_busy_bad = 1'b1;
      if (r_valid) begin
        if (got == stall_beat) begin
          r_ready = 1'b0; sd = r_data; sl = r_last; si = r_id; sr = r_resp; r0 = ren_cnt;
          repeat (stall_len) begin
            @(negedge clk);
            if (!r_valid || r_data !== sd || r_last !== sl || r_id !== si || r_resp !== sr || ar_ready)
              stable_bad = 1'b1;
          end
          stall_ren = ren_cnt - r0;
          r_ready = 1'b1;
        end
        b_data[got] = r_data; b_last[got] = r_last; b_resp[got] = r_resp;
        b_id[got] = r_id; b_cyc[got] = cyc;
        got++;
      end
    end
    tests++;
    if (got != n) begin
      fails++;
      $display("FAIL beat_count: got %0d required %0d", got, n);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (ar_ready !== 1'b0) begin fails++; $display("FAIL reset_ar_ready: %b required 0", ar_ready); end
    tests++;
    if ({r_valid, r_last, mem_ren} !== 3'b000) begin
      fails++; $display("FAIL reset_strobes: valid/last/ren=%b required 000", {r_valid, r_last, mem_ren});
    end
    tests++;
    if (r_data !== 64'd0 || r_id !== 4'd0 || r_resp !== 2'd0 || mem_addr !== 64'd0) begin
      fails++; $display("FAIL reset_data: data=%h id=%h resp=%h maddr=%h required all 0", r_data, r_id, r_resp, mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (ar_ready !== 1'b1) begin fails++; $display("FAIL release_ar_ready: %b required 1", ar_ready); end
  endtask
  task automatic test_single;
    int r0 = ren_cnt;
    send_ar(64'h8000_0000, 4'h3, 8'd0, BURST_INCR);
    collect(1, -1, 0);
    tests++;
    if (b_data[0] !== 64'h0000_0013_0000_0093) begin fails++; $display("FAIL single_data: %h required 0000001300000093", b_data[0]); end
    tests++;
    if (b_last[0] !== 1'b1 || b_resp[0] !== RESP_OKAY || b_id[0] !== 4'h3) begin
      fails++; $display("FAIL single_ctl: last=%b resp=%0d id=%h required 1 0 3", b_last[0], b_resp[0], b_id[0]);
    end
    tests++;
    if (b_cyc[0] - acc_cyc != 4) begin fails++; $display("FAIL single_latency: %0d required 4", b_cyc[0] - acc_cyc); end
    tests++;
    if (ren_cnt - r0 != 1 || alog[r0] !== 64'h8000_0000) begin
      fails++; $display("FAIL single_mem: reads=%0d addr=%h required 1 80000000", ren_cnt - r0, alog[r0]);
    end
  endtask
  task automatic test_incr8;
    int r0 = ren_cnt;
    logic [63:0] ea;
    send_ar(64'h8000_0040, 4'h5, 8'd7, BURST_INCR);
    collect(8, -1, 0);
    for (int i = 0; i < 8; i++) begin
      ea = 64'h8000_0040 + 64'(8 * i);
      tests++;
      if (alog[r0 + i] !== ea) begin fails++; $display("FAIL incr_addr[%0d]: %h required %h", i, alog[r0 + i], ea); end
      tests++;
      if (b_data[i] !== mem_word(ea) || b_id[i] !== 4'h5 || b_last[i] !== (i == 7)) begin
        fails++; $display("FAIL incr_beat[%0d]: data=%h id=%h last=%b required %h 5 %b", i, b_data[i], b_id[i], b_last[i], mem_word(ea), i == 7);
      end
      if (i > 0) begin
        tests++;
        if (b_cyc[i] - b_cyc[i-1] != 2) begin fails++; $display("FAIL incr_spacing[%0d]: %0d required 2", i, b_cyc[i] - b_cyc[i-1]); end
      end
    end
    tests++;
    if (ar_busy_bad !== 1'b0) begin fails++; $display("FAIL incr_ar_busy: ar_ready seen high mid-burst, required low"); end
  endtask
  task automatic test_wrap;
    int r0 = ren_cnt;
    logic [63:0] wa [0:3];
    wa[0] = 64'h8000_0018; wa[1] = 64'h8000_0000; wa[2] = 64'h8000_0008; wa[3] = 64'h8000_0010;
    send_ar(64'h8000_0018, 4'h2, 8'd3, BURST_WRAP);
    collect(4, -1, 0);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (alog[r0 + i] !== wa[i] || b_data[i] !== mem_word(wa[i]) || b_last[i] !== (i == 3) || b_resp[i] !== RESP_OKAY) begin
        fails++; $display("FAIL wrap_beat[%0d]: addr=%h data=%h last=%b resp=%0d required %h %h %b 0", i, alog[r0 + i], b_data[i], b_last[i], b_resp[i], wa[i], mem_word(wa[i]), i == 3);
      end
    end
  endtask
  task automatic test_errors;
    logic [63:0] ca [0:5];
    logic [7:0]  cl [0:5];
    logic [1:0]  cb [0:5];
    logic        ce [0:5];
    int r0;
    logic [63:0] ea;
    ca[0] = 64'h8000_0004; cl[0] = 8'd1; cb[0] = BURST_INCR; ce[0] = 1'b1;
    ca[1] = 64'h8000_0000; cl[1] = 8'd8; cb[1] = BURST_INCR; ce[1] = 1'b1;
    ca[2] = 64'h8000_0FF8; cl[2] = 8'd1; cb[2] = BURST_INCR; ce[2] = 1'b1;
    ca[3] = 64'h8000_0000; cl[3] = 8'd1; cb[3] = 2'd3;       ce[3] = 1'b1;
    ca[4] = 64'h8000_0000; cl[4] = 8'd2; cb[4] = BURST_WRAP; ce[4] = 1'b1;
    ca[5] = 64'h8000_0FF0; cl[5] = 8'd1; cb[5] = BURST_INCR; ce[5] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      r0 = ren_cnt;
      send_ar(ca[c], 4'(c + 8), cl[c], cb[c]);
      collect(int'(cl[c]) + 1, -1, 0);
      tests++;
      if (ren_cnt - r0 != (ce[c] ? 0 : int'(cl[c]) + 1)) begin
        fails++; $display("FAIL err_reads[%0d]: %0d required %0d", c, ren_cnt - r0, ce[c] ? 0 : int'(cl[c]) + 1);
      end
      for (int i = 0; i <= int'(cl[c]); i++) begin
        ea = ca[c] + 64'(8 * i);
        tests++;
        if (b_resp[i] !== (ce[c] ? RESP_SLVERR : RESP_OKAY) || b_data[i] !== (ce[c] ? 64'd0 : mem_word(ea)) || b_last[i] !== (i == int'(cl[c]))) begin
          fails++; $display("FAIL err_beat[%0d][%0d]: resp=%0d data=%h last=%b required %0d %h %b", c, i, b_resp[i], b_data[i], b_last[i], ce[c] ? 2 : 0, ce[c] ? 64'd0 : mem_word(ea), i == int'(cl[c]));
        end
      end
    end
  endtask
  task automatic test_backpressure;
    int r0 = ren_cnt;
    logic [63:0] ea;
    send_ar(64'h8000_0100, 4'h6, 8'd3, BURST_INCR);
    collect(4, 1, 5);
    tests++;
    if (stable_bad !== 1'b0) begin fails++; $display("FAIL bp_stable: outputs changed while stalled, required held"); end
    tests++;
    if (stall_ren != 0) begin fails++; $display("FAIL bp_ren: %0d reads during stall required 0", stall_ren); end
    tests++;
    if (ren_cnt - r0 != 4) begin fails++; $display("FAIL bp_reads: %0d required 4", ren_cnt - r0); end
    tests++;
    if (b_cyc[2] - b_cyc[1] != 2) begin fails++; $display("FAIL bp_resume: %0d required 2", b_cyc[2] - b_cyc[1]); end
    for (int i = 0; i < 4; i++) begin
      ea = 64'h8000_0100 + 64'(8 * i);
      tests++;
      if (b_data[i] !== mem_word(ea) || b_last[i] !== (i == 3) || b_id[i] !== 4'h6) begin
        fails++; $display("FAIL bp_beat[%0d]: data=%h last=%b id=%h required %h %b 6", i, b_data[i], b_last[i], b_id[i], mem_word(ea), i == 3);
      end
    end
    @(negedge clk);
    tests++;
    if (ar_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after: %b required 1", ar_ready); end
  endtask
  task automatic test_reset_midburst;
    int g = 0;
    int r0;
    logic bad = 1'b0;
    send_ar(64'h8000_0200, 4'h7, 8'd7, BURST_INCR);
    collect(2, -1, 0);
    @(negedge clk);
    while (!r_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    tests++;
    if (r_valid !== 1'b1) begin fails++; $display("FAIL rst_beat3_valid: %b required 1", r_valid); end
    rst = 1'b1;
    #1;
    tests++;
    if ({r_valid, r_last, mem_ren, ar_ready} !== 4'b0000 || r_data !== 64'd0 || r_id !== 4'd0) begin
      fails++; $display("FAIL rst_abort: valid/last/ren/ready=%b data=%h id=%h required 0000 0 0", {r_valid, r_last, mem_ren, ar_ready}, r_data, r_id);
    end
    r0 = ren_cnt;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (ar_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: %b required 1", ar_ready); end
    repeat (4) begin
      @(negedge clk);
      if (r_valid || mem_ren) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0 || ren_cnt != r0) begin fails++; $display("FAIL rst_quiet: activity after abort, reads=%0d required 0", ren_cnt - r0); end
    send_ar(64'h8000_0000, 4'h9, 8'd0, BURST_INCR);
    collect(1, -1, 0);
    tests++;
    if (b_data[0] !== 64'h0000_0013_0000_0093 || b_last[0] !== 1'b1 || b_id[0] !== 4'h9 || b_resp[0] !== RESP_OKAY) begin
      fails++; $display("FAIL rst_next_burst: data=%h last=%b id=%h resp=%0d required 0000001300000093 1 9 0", b_data[0], b_last[0], b_id[0], b_resp[0]);
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_incr8;
    test_wrap;
    test_errors;
    test_backpressure;
    test_reset_midburst;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/icache_refill_responder.md
# icache_refill_responder

Memory-side AXI4 read responder that serves I-cache line refills: accepts one read burst on the AR channel, fetches each 64-bit beat from a synchronous backing-memory read port, and returns the beats on the R channel with full valid/ready back-pressure. It sits between the instruction-cache miss path and main memory, and stands in for the memory model during simulation and bring-up. Access latency is programmable so the cache's miss-handling timing can be exercised.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, beat width (8 bytes)
- ID_W, 4, transaction ID width
- LATENCY, 2, idle cycles inserted between AR accept and the first memory read (0 allowed)
- MAX_LEN, 8, maximum beats per burst
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ar_valid  in  1  request valid
- ar_ready  out  1  request accepted
- ar_addr  in  ADDR_W  start address
- ar_id  in  ID_W  transaction ID
- ar_len  in  8  beats minus 1
- ar_burst  in  2  burst type: 0 = FIXED, 1 = INCR, 2 = WRAP, 3 = reserved
- r_valid  out  1  beat valid
- r_ready  in  1  beat accepted
- r_data  out  DATA_W  beat data
- r_id  out  ID_W  echoed ar_id
- r_resp  out  2  response: 0 = OKAY, 2 = SLVERR
- r_last  out  1  final beat of the burst
- mem_ren  out  1  backing-memory read strobe
- mem_addr  out  ADDR_W  backing-memory beat address (8-byte aligned)
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_ren

## Operation
- States:
  - IDLE: ar_ready = 1.
  - WAIT: latency counter runs.
  - READ: mem_ren = 1 for exactly one cycle.
  - DATA: r_valid = 1.
- IDLE → on ar_valid && ar_ready:
  - latch addr, id, len and burst; beat counter = 0; error flag = error check.
  - next state is WAIT if LATENCY > 0 and no error, else READ.
- WAIT → READ once LATENCY cycles have elapsed.
- READ → DATA:
  - r_data ← mem_rdata on OKAY beats; r_data = 0 on error beats.
  - On error, mem_ren stays 0 for the whole burst.
- DATA, r_valid && r_ready:
  - if r_last: go to IDLE;
  - else advance the address, increment the beat counter, and go to READ (no WAIT between beats).
- r_data, r_id, r_resp and r_last are held stable while r_valid && !r_ready.
- The error flag is set, and every beat of the burst returns SLVERR, when any of these holds:
  - ar_addr[2:0] != 0;
  - ar_len + 1 > MAX_LEN;
  - ar_burst == 3;
  - WRAP with ar_len not in {1, 3, 7, 15};
  - INCR burst crossing a 4 KB boundary.
- An error burst still returns exactly ar_len + 1 beats, and r_last is asserted on the final one.
- Address advance per beat:
  - FIXED: unchanged.
  - INCR: +8.
  - WRAP: +8 within the aligned window of size (len + 1) × 8. Only the low bits are replaced: addr = (addr & ~mask) | ((addr + 8) & mask).
- r_last = 1 exactly when beat counter == len.

## Timing
- Reset values: ar_ready = 0 while rst is asserted, and 1 in the first cycle after release (IDLE). r_valid, r_last, mem_ren = 0; r_data, r_id, r_resp, mem_addr = 0.
- Accept at edge T; first mem_ren in cycle T + 1 + LATENCY; first r_valid in cycle T + 2 + LATENCY.
- Each subsequent beat: r_valid is high again 2 cycles after the previous handshake, so the best case is 1 beat every 2 cycles.
- ar_ready is low from the accept through the final R handshake; the next AR can be accepted in the cycle after the r_last handshake.
- rst asserted mid-burst aborts immediately: outputs take their reset values, no further beats are issued, the FSM returns to IDLE.
- r_ready stuck low holds the FSM in DATA indefinitely, with no further mem_ren.

## Structure
- Package icache_refill_pkg holds:
  - burst encodings (BURST_FIXED/INCR/WRAP);
  - response encodings (RESP_OKAY/SLVERR);
  - the state enum (IDLE, WAIT, READ, DATA);
  - BEAT_BYTES = 8.
- Sub-module axi_burst_addr_gen: combinational next-address logic (addr, len, burst → next_addr) plus the 4 KB-cross and WRAP-length checks.

## Test plan
- LATENCY = 2, INCR, addr 0x8000_0000, len 0, memory word 0x0000_0013_0000_0093 → one beat with r_data equal to that word, r_last = 1, OKAY, r_valid 4 cycles after accept.
- INCR, addr 0x8000_0040, len 7, r_ready always 1 → mem_addr 0x...40 through 0x...78 in steps of 8; r_last on beat 8 only; ID echoed.
- WRAP, addr 0x8000_0018, len 3 → beat addresses 0x18, 0x00, 0x08, 0x10; r_last on the fourth beat.
- Errors: addr 0x8000_0004, len 1 → 2 beats of SLVERR with data 0 and no mem_ren. Also: len 8 with MAX_LEN = 8 → SLVERR; INCR from 0x...FF8 with len 1 → SLVERR.
- Back-pressure: r_ready low for 5 cycles on beat 2 → r_data, r_last and r_id held stable, no extra mem_ren, burst completes correctly afterwards.
- rst pulsed during beat 3 of an 8-beat burst → r_valid = 0 immediately; ar_ready = 1 after release; a new len-0 burst then completes normally.
